// File: rtl/calc2_pkg.sv
// rtl/calc2_pkg.sv - shared widths, command/response encodings and op record for the calc2 request path
package calc2_pkg;

    localparam int CMD_W    = 4;
    localparam int DATA_W   = 32;
    localparam int TAG_W    = 2;
    localparam int RESP_W   = 2;
    localparam int NUM_TAGS = 1 << TAG_W;

    typedef enum logic [CMD_W-1:0] {
        NOP = 4'd0,
        ADD = 4'd1,
        SUB = 4'd2,
        SHL = 4'd5,
        SHR = 4'd6
    } calc2_cmd_e;

    typedef enum logic [RESP_W-1:0] {
        NONE = 2'd0,
        OK   = 2'd1,
        ERR  = 2'd2,
        RSVD = 2'd3
    } calc2_resp_e;

    // cmd is kept as raw bits so unlisted opcodes pass through untouched
    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
    } calc2_op_t;

    // Lowest-numbered tag whose busy bit is clear; 0 when none is free
    function automatic logic [TAG_W-1:0] lowest_free_tag(input logic [NUM_TAGS-1:0] busy);
        lowest_free_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                lowest_free_tag = TAG_W'(i);
            end
        end
    endfunction

    // Number of busy tags, wide enough to hold NUM_TAGS itself
    function automatic logic [TAG_W:0] popcount_tags(input logic [NUM_TAGS-1:0] busy);
        popcount_tags = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            popcount_tags = popcount_tags + {{TAG_W{1'b0}}, busy[i]};
        end
    endfunction

endpackage

// File: rtl/calc2_req_fifo.sv
// rtl/calc2_req_fifo.sv - synchronous op FIFO with wrap-bit pointers and registered ready
module calc2_req_fifo
    import calc2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      c_clk,
    input  logic      reset,
    input  logic      push_i,
    input  calc2_op_t push_data_i,
    input  logic      pop_i,
    output calc2_op_t pop_data_o,
    output logic      empty_o,
    output logic      ready_o
);

    localparam int AW = $clog2(DEPTH);

    calc2_op_t   mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        ready_q;
    logic        full;
    logic        full_d;
    logic        do_push;
    logic        do_pop;

    // Same index with opposite wrap bit means every slot is occupied
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A full FIFO refuses a push even when a pop frees a slot on the same edge
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty_o;

    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];
    assign ready_o    = ready_q;

    // Next pointer values, and the fullness they imply for the registered ready
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    // Pointer and ready registers; ready stays low throughout reset
    always_ff @(posedge c_clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= !full_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge c_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/calc2_req_issuer.sv
// rtl/calc2_req_issuer.sv - per-port op buffer, tag allocator and two-beat calc2 request driver
module calc2_req_issuer
    import calc2_pkg::*;
#(
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CMD_W-1:0]  in_cmd,
    input  logic [DATA_W-1:0] in_op1,
    input  logic [DATA_W-1:0] in_op2,
    output logic [CMD_W-1:0]  req_cmd_out,
    output logic [DATA_W-1:0] req_data_out,
    output logic [TAG_W-1:0]  req_tag_out,
    input  logic [RESP_W-1:0] resp_in,
    input  logic [DATA_W-1:0] resp_data_in,
    input  logic [TAG_W-1:0]  resp_tag_in,
    output logic              cpl_valid,
    output logic [RESP_W-1:0] cpl_resp,
    output logic [DATA_W-1:0] cpl_data,
    output logic [TAG_W-1:0]  cpl_tag,
    output logic [CMD_W-1:0]  cpl_cmd,
    output logic [TAG_W:0]    outstanding,
    output logic              err_unexpected
);

    localparam logic [TAG_W:0] MAX_OUT = (TAG_W + 1)'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OP1  = 2'd1,
        S_OP2  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_TAGS-1:0] busy_q, busy_d;
    logic [CMD_W-1:0]    tag_cmd_q [NUM_TAGS];
    logic [DATA_W-1:0]   op2_q, op2_d;

    logic [CMD_W-1:0]    req_cmd_q, req_cmd_d;
    logic [DATA_W-1:0]   req_data_q, req_data_d;
    logic [TAG_W-1:0]    req_tag_q, req_tag_d;

    logic                cpl_valid_q;
    logic [RESP_W-1:0]   cpl_resp_q;
    logic [DATA_W-1:0]   cpl_data_q;
    logic [TAG_W-1:0]    cpl_tag_q;
    logic [CMD_W-1:0]    cpl_cmd_q;
    logic [TAG_W:0]      outstanding_q;
    logic                err_q;

    calc2_op_t           in_op;
    calc2_op_t           head;
    logic                fifo_empty;
    logic                push;
    logic                alloc;
    logic                issue_ok;
    logic [TAG_W-1:0]    alloc_tag;
    logic                resp_hit;
    logic                resp_miss;

    assign in_op = '{cmd: in_cmd, op1: in_op1, op2: in_op2};
    assign push  = in_valid && in_ready;

    calc2_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .c_clk       (c_clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (in_op),
        .pop_i       (alloc),
        .pop_data_o  (head),
        .empty_o     (fifo_empty),
        .ready_o     (in_ready)
    );

    // Allocation always looks at the busy vector before this edge, so a tag
    // freed by a response on the same edge only becomes usable one edge later
    assign alloc_tag = lowest_free_tag(busy_q);
    assign issue_ok  = !fifo_empty && !(&busy_q) && (popcount_tags(busy_q) < MAX_OUT);

    assign resp_hit  = (resp_in != NONE) && busy_q[resp_tag_in];
    assign resp_miss = (resp_in != NONE) && !busy_q[resp_tag_in];

    // Issue FSM: computes the next state and the next registered request beat
    always_comb begin
        state_d    = state_q;
        alloc      = 1'b0;
        op2_d      = op2_q;
        req_cmd_d  = NOP;
        req_data_d = '0;
        req_tag_d  = '0;
        case (state_q)
            S_IDLE, S_OP2: begin
                if (issue_ok) begin
                    state_d    = S_OP1;
                    alloc      = 1'b1;
                    req_cmd_d  = head.cmd;
                    req_data_d = head.op1;
                    req_tag_d  = alloc_tag;
                    op2_d      = head.op2;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OP1: begin
                state_d    = S_OP2;
                req_data_d = op2_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Busy vector update: a hit frees its tag, an issue claims the allocated one
    always_comb begin
        busy_d = busy_q;
        if (resp_hit) begin
            busy_d[resp_tag_in] = 1'b0;
        end
        if (alloc) begin
            busy_d[alloc_tag] = 1'b1;
        end
    end

    // State, request, tag table, completion and status registers
    always_ff @(posedge c_clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            busy_q        <= '0;
            op2_q         <= '0;
            req_cmd_q     <= '0;
            req_data_q    <= '0;
            req_tag_q     <= '0;
            cpl_valid_q   <= 1'b0;
            cpl_resp_q    <= '0;
            cpl_data_q    <= '0;
            cpl_tag_q     <= '0;
            cpl_cmd_q     <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            for (int i = 0; i < NUM_TAGS; i++) begin
                tag_cmd_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            op2_q         <= op2_d;
            req_cmd_q     <= req_cmd_d;
            req_data_q    <= req_data_d;
            req_tag_q     <= req_tag_d;
            cpl_valid_q   <= resp_hit;
            cpl_resp_q    <= resp_hit ? resp_in : '0;
            cpl_data_q    <= resp_hit ? resp_data_in : '0;
            cpl_tag_q     <= resp_hit ? resp_tag_in : '0;
            cpl_cmd_q     <= resp_hit ? tag_cmd_q[resp_tag_in] : '0;
            outstanding_q <= popcount_tags(busy_d);
            err_q         <= err_q || resp_miss;
            if (alloc) begin
                tag_cmd_q[alloc_tag] <= head.cmd;
            end
        end
    end

    assign req_cmd_out    = req_cmd_q;
    assign req_data_out   = req_data_q;
    assign req_tag_out    = req_tag_q;
    assign cpl_valid      = cpl_valid_q;
    assign cpl_resp       = cpl_resp_q;
    assign cpl_data       = cpl_data_q;
    assign cpl_tag        = cpl_tag_q;
    assign cpl_cmd        = cpl_cmd_q;
    assign outstanding    = outstanding_q;
    assign err_unexpected = err_q;

endmodule
